// File: rtl/dec_op_pkg.sv
// -----------------------------------------------------------------------------
// dec_op_pkg
// Shared definitions for the decoded operation selector (dec_op_if).
//   - Operation select codes, which are also the result lane indices.
//   - Operand and result widths.
//   - res_bank_t: one result byte per lane, with lane i at index i.
// -----------------------------------------------------------------------------
package dec_op_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CAT = 2'b11;

  localparam int OPW   = 4;
  localparam int RESW  = 8;
  localparam int NLANE = 4;

  typedef logic [NLANE-1:0][RESW-1:0] res_bank_t;

  // Zero-extend an operand to the result width.
  function automatic logic [RESW-1:0] widen(input logic [OPW-1:0] v);
    return {{(RESW-OPW){1'b0}}, v};
  endfunction

endpackage : dec_op_pkg

// File: rtl/dec2to4.sv
// -----------------------------------------------------------------------------
// dec2to4
// Combinational 2-to-4 decoder with an enable input.
// Ports:
//   EN  in  1  1 = drive the one-hot output, 0 = all outputs low
//   D   in  2  binary select
//   Y   out 4  one-hot decode of D (Y[D] = 1), or all zeros when EN = 0
// -----------------------------------------------------------------------------
module dec2to4 (
  input  logic       EN,
  input  logic [1:0] D,
  output logic [3:0] Y
);

  assign Y = EN ? (4'b0001 << D) : 4'b0000;

endmodule : dec2to4

// File: rtl/dec_op_if.sv
// -----------------------------------------------------------------------------
// dec_op_if
// Operation selector. DEC is decoded to a one-hot lane select. Only the
// selected lane is loaded with its result; every other lane is loaded with
// zero. All outputs are registered, with a latency of one clock.
// Ports:
//   CLK     in   1  rising-edge clock
//   RST     in   1  synchronous, active-high reset; clears all lanes
//   A       in   4  operand A, unsigned
//   B       in   4  operand B, unsigned
//   DEC     in   2  operation select (OP_ADD / OP_SUB / OP_MUL / OP_CAT)
//   ENABLE  in   1  1 = execute the selected operation, 0 = all lanes load 0
//   op0     out  8  lane 0: A + B
//   op1     out  8  lane 1: A - B, modulo 256
//   op2     out  8  lane 2: A * B, unsigned
//   op3     out  8  lane 3: {A, B}
// -----------------------------------------------------------------------------
module dec_op_if
  import dec_op_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  input  logic [1:0]      DEC,
  input  logic            ENABLE,
  output logic [RESW-1:0] op0,
  output logic [RESW-1:0] op1,
  output logic [RESW-1:0] op2,
  output logic [RESW-1:0] op3
);

  logic [NLANE-1:0] sel;
  logic [RESW-1:0]  a_w, b_w;
  res_bank_t        op_d, op_q;

  // ENABLE is folded into the decoder, so a disabled block selects no lane.
  dec2to4 u_dec2to4 (
    .EN (ENABLE),
    .D  (DEC),
    .Y  (sel)
  );

  assign a_w = widen(A);
  assign b_w = widen(B);

  // NOTE: op_d is fully assigned before any lane is conditionally overwritten,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_d = '0;
    if (sel[OP_ADD]) op_d[OP_ADD] = a_w + b_w;
    // The 8-bit subtraction wraps, giving the two's complement result for A < B.
    if (sel[OP_SUB]) op_d[OP_SUB] = a_w - b_w;
    // The product of two 4-bit values is at most 225, so 8 bits are enough.
    if (sel[OP_MUL]) op_d[OP_MUL] = a_w * b_w;
    if (sel[OP_CAT]) op_d[OP_CAT] = {A, B};
  end

  // NOTE: Register state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  assign op0 = op_q[OP_ADD];
  assign op1 = op_q[OP_SUB];
  assign op2 = op_q[OP_MUL];
  assign op3 = op_q[OP_CAT];

endmodule : dec_op_if

// File: tb/tb_dec_op_if.sv
// -----------------------------------------------------------------------------
// tb_dec_op_if
// Scoreboard bench for dec_op_if. The driver applies one input set per clock
// and pushes the expected lane values from a behavioural model into a queue.
// The monitor pops one entry after each rising edge and compares all four
// lanes against it.
// -----------------------------------------------------------------------------
module tb_dec_op_if;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] A, B;
  logic [1:0] DEC;
  logic       ENABLE;
  logic [7:0] op0, op1, op2, op3;

  typedef logic [3:0][7:0] lanes_t;

  lanes_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  dec_op_if dut (
    .CLK    (CLK),
    .RST    (RST),
    .A      (A),
    .B      (B),
    .DEC    (DEC),
    .ENABLE (ENABLE),
    .op0    (op0),
    .op1    (op1),
    .op2    (op2),
    .op3    (op3)
  );

  always #5 CLK = ~CLK;

  // Reference model. Lane number = operation code. Results are computed with
  // integer arithmetic and reduced to one byte.
  function automatic lanes_t model(input bit rst, input bit en, input int dec,
                                   input int a, input int b);
    lanes_t r;
    int     v;
    r = '0;
    if (rst || !en) return r;
    case (dec)
      0:       v = a + b;
      1:       v = a - b;
      2:       v = a * b;
      default: v = a * 16 + b;
    endcase
    r[dec] = 8'(v & 255);
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input set midway between rising edges and record the response
  // expected after the next rising edge.
  task automatic drive(input bit rst, input bit en, input int dec, input int a, input int b);
    @(negedge CLK);
    RST    = rst;
    ENABLE = en;
    DEC    = 2'(dec);
    A      = 4'(a);
    B      = 4'(b);
    exp_q.push_back(model(rst, en, dec, a, b));
  endtask

  // Monitor: each rising edge retires one expected entry.
  initial begin
    lanes_t e, act;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {op3, op2, op1, op0};
        for (int i = 0; i < 4; i++)
          check($sformatf("op%0d", i), act[i], e[i]);
      end
    end
  end

  initial begin
    int waited;
    RST = 1'b1; ENABLE = 1'b1; DEC = 2'b00; A = 4'hF; B = 4'hF;

    // Reset held with an active operation on the inputs.
    drive(1, 1, 0, 15, 15);
    drive(1, 1, 0, 15, 15);

    // Add lane.
    drive(0, 1, 0, 1, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 15, 15);
    // Subtract lane, including a negative result.
    drive(0, 1, 1, 2, 2);
    drive(0, 1, 1, 1, 3);
    drive(0, 1, 1, 0, 15);
    // Multiply lane.
    drive(0, 1, 2, 3, 3);
    drive(0, 1, 2, 4, 4);
    drive(0, 1, 2, 15, 15);
    // Concatenate lane.
    drive(0, 1, 3, 7, 7);
    drive(0, 1, 3, 10, 5);

    // Disabled: every lane loads zero regardless of the other inputs.
    for (int d = 0; d < 4; d++)
      for (int v = 0; v < 8; v++)
        drive(0, 0, d, v, v);

    // Reset in the middle of an operation discards the result.
    drive(0, 1, 2, 4, 4);
    drive(1, 1, 2, 4, 4);
    drive(0, 1, 2, 4, 4);

    // Randomized traffic with occasional reset and disable.
    for (int n = 0; n < 400; n++)
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(15)));

    // Let the monitor retire the remaining entries, within a cycle budget.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      #2;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dec_op_if
